// File: rtl/me_search_col_ctrl.sv
// me_search_col_ctrl: ping-pong sequencer for the two-column search-window buffer.
// One bank fills from the search-pixel stream while the other streams to the PE array.
// Optional build macro ME_SEARCH_CTRL_STATS_EN adds the stall_cycles counter output.
module me_search_col_ctrl #(
   parameter int unsigned COL_DEPTH = 47,
   parameter int unsigned NUM_COLS  = 32,
   parameter int unsigned ADDR_W    = 7,
   parameter int unsigned DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              search_write,
   output logic [ADDR_W-1:0] search_write_addr,
   output logic [DATA_W-1:0] search_write_data,
   output logic              search_read,
   output logic [ADDR_W-1:0] search_read_addr,
   input  logic [DATA_W-1:0] search_data_out,
   input  logic              pe_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_col_last
`ifdef ME_SEARCH_CTRL_STATS_EN
   ,
   output logic [15:0]       stall_cycles
`endif
);

   localparam int unsigned CNT_W = $clog2(NUM_COLS + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StRead = 2'd2;
   localparam logic [1:0] StLast = 2'd3;

   if (2 * COL_DEPTH > (2 ** ADDR_W)) begin : g_addr_check
      $error("me_search_col_ctrl: two banks of COL_DEPTH do not fit in ADDR_W bits");
   end

   logic [1:0]        state_q, state_d;
   logic              busy_q, done_q;
   logic [1:0]        full_q, full_d;
   logic              wr_bank_q, rd_bank_q;
   logic [ADDR_W-1:0] wr_idx_q, rd_idx_q;
   logic [CNT_W-1:0]  wr_cols_q, rd_cols_q;
   logic              out_valid_q, out_col_last_q;

   logic              start_acc, wr_hs, wr_wrap, rd_last_pix, rd_final;
   logic [ADDR_W-1:0] wr_base, rd_base;

   assign start_acc   = start && (state_q == StIdle);
   assign in_ready    = busy_q && !full_q[wr_bank_q] && (wr_cols_q < CNT_W'(NUM_COLS));
   assign wr_hs       = in_valid && in_ready;
   assign wr_wrap     = wr_hs && (wr_idx_q == ADDR_W'(COL_DEPTH - 1));
   assign wr_base     = wr_bank_q ? ADDR_W'(COL_DEPTH) : {ADDR_W{1'b0}};
   assign rd_base     = rd_bank_q ? ADDR_W'(COL_DEPTH) : {ADDR_W{1'b0}};
   assign search_read = (state_q == StRead);
   assign rd_last_pix = search_read && (rd_idx_q == ADDR_W'(COL_DEPTH - 1));
   assign rd_final    = (rd_cols_q == CNT_W'(NUM_COLS - 1));

   // Write port is a same-cycle passthrough, zeroed when no handshake is taking place.
   assign search_write      = wr_hs;
   assign search_write_addr = wr_hs ? (wr_base + wr_idx_q) : {ADDR_W{1'b0}};
   assign search_write_data = wr_hs ? in_data : {DATA_W{1'b0}};
   assign search_read_addr  = search_read ? (rd_base + rd_idx_q) : {ADDR_W{1'b0}};

   assign busy         = busy_q;
   assign done         = done_q;
   assign out_valid    = out_valid_q;
   assign out_data     = search_data_out;
   assign out_col_last = out_col_last_q;

   // Bank-full flags: the writer sets and the reader clears, both may land in one cycle.
   always_comb begin
      full_d = full_q;
      if (wr_wrap) full_d[wr_bank_q] = 1'b1;
      if (state_q == StLast) full_d[rd_bank_q] = 1'b0;
      if (start_acc) full_d = 2'b00;
   end

   // Read FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StWait;
         StWait: if (full_q[rd_bank_q] && pe_ready) state_d = StRead;
         StRead: if (rd_idx_q == ADDR_W'(COL_DEPTH - 1)) state_d = StLast;
         StLast: state_d = rd_final ? StIdle : StWait;
         default: state_d = StIdle;
      endcase
   end

   // Control state: window start, writer indices and reader indices.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         full_q         <= 2'b00;
         wr_bank_q      <= 1'b0;
         rd_bank_q      <= 1'b0;
         wr_idx_q       <= '0;
         rd_idx_q       <= '0;
         wr_cols_q      <= '0;
         rd_cols_q      <= '0;
         out_valid_q    <= 1'b0;
         out_col_last_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         full_q         <= full_d;
         done_q         <= 1'b0;
         out_valid_q    <= search_read;
         out_col_last_q <= rd_last_pix;
         if (start_acc) begin
            busy_q    <= 1'b1;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            wr_cols_q <= '0;
            rd_cols_q <= '0;
         end
         if (wr_hs) begin
            wr_idx_q <= wr_wrap ? '0 : wr_idx_q + 1'b1;
            if (wr_wrap) begin
               wr_bank_q <= ~wr_bank_q;
               wr_cols_q <= wr_cols_q + 1'b1;
            end
         end
         if (state_q == StWait && state_d == StRead) rd_idx_q <= '0;
         if (search_read) rd_idx_q <= rd_idx_q + 1'b1;
         if (state_q == StLast) begin
            rd_bank_q <= ~rd_bank_q;
            rd_cols_q <= rd_cols_q + 1'b1;
            if (rd_final) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

`ifdef ME_SEARCH_CTRL_STATS_EN
   logic [15:0] stall_q;

   // Saturating count of cycles where the PE array waits on an unfilled bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if (state_q == StWait && pe_ready && !full_q[rd_bank_q] &&
                   stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule
